// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write-side bundle for fifo_wr_arbiter.
// master = the arbiter, slave = the producers plus the FIFO write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
);
  logic                          en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic                          fifo_wr_ack;
  logic                          fifo_ovf;
  logic                          stall;
  logic                          ack_err;
  logic                          ovf_err;
  logic [CNT_W-1:0]              wr_cnt;
  logic [CNT_W-1:0]              nack_cnt;

  modport master (
    input  en, req, req_data, fifo_full, fifo_afull, fifo_wr_ack, fifo_ovf,
    output gnt, fifo_wr_en, fifo_data_in, stall, ack_err, ovf_err, wr_cnt, nack_cnt
  );

  modport slave (
    output en, req, req_data, fifo_full, fifo_afull, fifo_wr_ack, fifo_ovf,
    input  gnt, fifo_wr_en, fifo_data_in, stall, ack_err, ovf_err, wr_cnt, nack_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with full/almostfull throttling, write-ack checking and write statistics.
//
// state | meaning
// IDLE  | no request pending or arbiter disabled
// WRITE | issuing a write this cycle
// STALL | requests pending but FIFO may not accept; stall=1
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, WRITE, STALL} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic             win_found;
  logic             any_req;
  logic             ok;
  logic             ack_pend;

  assign any_req = |bus.req;
  // Only free space is considered (no credit for reads), so this never overflows.
  assign ok      = bus.en && !bus.fifo_full && !(bus.fifo_afull && bus.fifo_wr_en);
  assign bus.stall = (state == STALL);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(ptr) + i >= NUM_REQ) cand = PTR_W'(int'(ptr) + i - NUM_REQ);
      else                          cand = PTR_W'(int'(ptr) + i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req && ok)          state_nxt = WRITE;
        else if (any_req && bus.en) state_nxt = STALL;
      end
      WRITE, STALL: begin
        if (!any_req || !bus.en) state_nxt = IDLE;
        else if (ok)             state_nxt = WRITE;
        else                     state_nxt = STALL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= '0;
      bus.gnt          <= '0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_data_in <= '0;
      ack_pend         <= 1'b0;
      bus.ack_err      <= 1'b0;
      bus.ovf_err      <= 1'b0;
      bus.wr_cnt       <= '0;
      bus.nack_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      ack_pend <= bus.fifo_wr_en;

      if (ok && win_found) begin
        bus.fifo_wr_en   <= 1'b1;
        bus.gnt          <= NUM_REQ'(1) << win_idx;
        bus.fifo_data_in <= bus.req_data[win_idx*FIFO_WIDTH +: FIFO_WIDTH];
        ptr              <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      end else begin
        bus.fifo_wr_en <= 1'b0;
        bus.gnt        <= '0;
      end

      if (bus.fifo_wr_en && (bus.wr_cnt != '1)) bus.wr_cnt <= bus.wr_cnt + CNT_W'(1);

      // ack for the write of the previous cycle must be present now
      if (ack_pend && !bus.fifo_wr_ack) begin
        bus.ack_err <= 1'b1;
        if (bus.nack_cnt != '1) bus.nack_cnt <= bus.nack_cnt + CNT_W'(1);
      end

      if (bus.fifo_ovf) bus.ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a depth-8 FIFO write-side model.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int FIFO_WIDTH = 16;
  localparam int CNT_W      = 4;
  localparam int DEPTH      = 8;

  logic clk;
  logic rst;
  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .CNT_W(CNT_W)) bus();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt;
  logic ack_r, ovf_r;
  logic rd_pop, drop_ack, ovf_inj;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.req_data    = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
  assign bus.fifo_full   = (cnt == DEPTH);
  assign bus.fifo_afull  = (cnt == DEPTH - 1);
  assign bus.fifo_wr_ack = ack_r;
  assign bus.fifo_ovf    = ovf_r | ovf_inj;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 0;
      ack_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      ack_r <= bus.fifo_wr_en && (cnt < DEPTH) && !drop_ack;
      ovf_r <= bus.fifo_wr_en && (cnt == DEPTH);
      cnt   <= cnt + ((bus.fifo_wr_en && cnt < DEPTH) ? 1 : 0) - ((rd_pop && cnt > 0) ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_wr, n_g;
    logic gate_prev;

    rst = 1'b1; bus.en = 1'b1; bus.req = 4'b1111;
    rd_pop = 1'b0; drop_ack = 1'b0; ovf_inj = 1'b0;
    step(); step();
    check("rst_gnt",    32'(bus.gnt),          32'h0);
    check("rst_wr_en",  32'(bus.fifo_wr_en),   32'h0);
    check("rst_data",   32'(bus.fifo_data_in), 32'h0);
    check("rst_stall",  32'(bus.stall),        32'h0);
    check("rst_wr_cnt", 32'(bus.wr_cnt),       32'h0);
    check("rst_errs",   32'({bus.ack_err, bus.ovf_err, bus.nack_cnt}), 32'h0);

    // round-robin order 0,1,2,3,0 with all requesting
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_gnt",  32'(bus.gnt), 32'(1) << (k % 4));
      check("t1_data", 32'(bus.fifo_data_in), 32'hA000 + (k % 4));
    end
    bus.req = 4'b0000;
    step(); step();
    check("t1_wr_cnt", 32'(bus.wr_cnt),   32'd5);
    check("t1_nack",   32'(bus.nack_cnt), 32'd0);

    // single requester fills an empty depth-8 FIFO
    do_reset();
    bus.req = 4'b0100;
    n_wr = 0; gate_prev = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (gate_prev) check("t2_afull_gate", 32'(bus.fifo_wr_en), 32'h0);
      if (bus.fifo_wr_en) n_wr++;
      gate_prev = bus.fifo_afull && bus.fifo_wr_en;
    end
    check("t2_writes",  32'(n_wr),          32'd8);
    check("t2_stall",   32'(bus.stall),     32'h1);
    check("t2_full",    32'(bus.fifo_full), 32'h1);
    check("t2_gnt",     32'(bus.gnt),       32'h0);
    check("t2_ovf_err", 32'(bus.ovf_err),   32'h0);
    check("t2_wr_cnt",  32'(bus.wr_cnt),    32'd8);

    // one pop from full -> exactly one more grant, then stall again
    rd_pop = 1'b1;
    step();
    rd_pop = 1'b0;
    n_g = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.gnt != '0) n_g++;
    end
    check("t3_grants",  32'(n_g),           32'd1);
    check("t3_stall",   32'(bus.stall),     32'h1);
    check("t3_full",    32'(bus.fifo_full), 32'h1);
    check("t3_wr_cnt",  32'(bus.wr_cnt),    32'd9);
    check("t3_ovf_err", 32'(bus.ovf_err),   32'h0);

    // pointer wrap: ptr=3 then ptr=1 with req=1001
    do_reset();
    bus.req = 4'b0100;
    step();
    check("t4_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1001;
    step();
    check("t4_p3_gnt3", 32'(bus.gnt),          32'h8);
    check("t4_p3_data", 32'(bus.fifo_data_in), 32'hA003);
    step();
    check("t4_p0_gnt0", 32'(bus.gnt),          32'h1);
    check("t4_p0_data", 32'(bus.fifo_data_in), 32'hA000);
    step();
    check("t4_p1_gnt3", 32'(bus.gnt), 32'h8);
    step();
    check("t4_p0_gnt0b", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;

    // dropped ack on the second of three writes; sticky ovf
    do_reset();
    bus.req = 4'b0001;
    step();
    step();
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    bus.req = 4'b0000;
    step(); step(); step();
    check("t5_nack_cnt", 32'(bus.nack_cnt), 32'd1);
    check("t5_ack_err",  32'(bus.ack_err),  32'h1);
    check("t5_wr_cnt",   32'(bus.wr_cnt),   32'd3);
    step(); step(); step();
    check("t5_ack_err_sticky", 32'(bus.ack_err),  32'h1);
    check("t5_nack_hold",      32'(bus.nack_cnt), 32'd1);
    check("t5_ovf_err_pre",    32'(bus.ovf_err),  32'h0);
    ovf_inj = 1'b1;
    step();
    ovf_inj = 1'b0;
    step(); step();
    check("t5_ovf_err_sticky", 32'(bus.ovf_err), 32'h1);

    // en falls mid-burst: the registered write completes, nothing more
    do_reset();
    bus.req = 4'b1111;
    step(); step();
    check("t6_inflight", 32'(bus.fifo_wr_en), 32'h1);
    bus.en = 1'b0;
    n_wr = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.fifo_wr_en) n_wr++;
    end
    check("t6_at_most_one", 32'(n_wr <= 1), 32'h1);
    check("t6_wr_cnt",      32'(bus.wr_cnt), 32'(2 + n_wr));
    check("t6_stall",       32'(bus.stall),  32'h0);
    check("t6_gnt",         32'(bus.gnt),    32'h0);
    bus.en  = 1'b1;
    bus.req = 4'b0000;

    // reset during a write kills it at once and clears the ack check
    do_reset();
    bus.req = 4'b0001;
    step();
    check("t6_pre_rst_wr_en", 32'(bus.fifo_wr_en), 32'h1);
    rst = 1'b1;
    #1;
    check("t6_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    check("t6_rst_gnt",   32'(bus.gnt),        32'h0);
    bus.req = 4'b0000;
    step();
    rst = 1'b0;
    step(); step();
    check("t6_rst_nack",    32'(bus.nack_cnt), 32'd0);
    check("t6_rst_ack_err", 32'(bus.ack_err),  32'h0);

    // write counter saturates at 2**CNT_W-1 while a reader drains
    do_reset();
    rd_pop  = 1'b1;
    bus.req = 4'b0010;
    for (int k = 0; k < 20; k++) step();
    bus.req = 4'b0000;
    step(); step();
    rd_pop = 1'b0;
    check("t7_wr_cnt_sat", 32'(bus.wr_cnt),  32'd15);
    check("t7_ovf_err",    32'(bus.ovf_err), 32'h0);
    check("t7_ack_err",    32'(bus.ack_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
